// File: rtl/rom_port_arbiter_pkg.sv
// Shared defaults and helpers for rom_port_arbiter and its round-robin picker.
package rom_port_arbiter_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned AW_DEF   = 3;
    localparam int unsigned DW_DEF   = 16;

    // ROM port indices into the per-port tag arrays
    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // Requester ID width: ceil(log2(n)), never below one bit
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Round-robin picker: selects up to two active requesters starting at ptr.
// Purely combinational; the caller owns the pointer register.
module rr_pick2
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win1,
    output logic [NREQ-1:0] win2,
    output logic [IW-1:0]   id1,
    output logic [IW-1:0]   id2,
    output logic            v1,
    output logic            v2,
    output logic [IW-1:0]   ptr_nxt
);

    int unsigned     idx;
    logic [IW-1:0]   last;

    // Scan from ptr with wrap; first hit goes to port 1, second to port 2
    always_comb begin
        win1    = '0;
        win2    = '0;
        id1     = '0;
        id2     = '0;
        v1      = 1'b0;
        v2      = 1'b0;
        idx     = 0;
        last    = '0;
        ptr_nxt = ptr;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[IW'(idx)]) begin
                if (!v1) begin
                    v1               = 1'b1;
                    id1              = IW'(idx);
                    win1[IW'(idx)]   = 1'b1;
                end else if (!v2) begin
                    v2               = 1'b1;
                    id2              = IW'(idx);
                    win2[IW'(idx)]   = 1'b1;
                end
            end
        end
        last = v2 ? id2 : id1;
        if (v1) begin
            ptr_nxt = (32'(last) + 1 >= NREQ) ? '0 : IW'(32'(last) + 1);
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the two read ports of a dual-address ROM among NREQ requesters.
// Grants are combinational; each granted read is tagged with its requester
// ID and the ROM output is steered back onto that requester's lane.
// Optional macro ROM_ARB_OUTREG_EN adds a registered output stage
// (latency 2, idle lanes hold their last data).
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [NREQ*DW-1:0] rdata,
    output logic               rom_en1,
    output logic               rom_en2,
    output logic [AW-1:0]      rom_addr1,
    output logic [AW-1:0]      rom_addr2,
    input  logic [DW-1:0]      rom_dout1,
    input  logic [DW-1:0]      rom_dout2
);

    localparam int unsigned IW = id_width(NREQ);

    logic [NREQ-1:0]       win1, win2;
    logic [IW-1:0]         id1, id2;
    logic                  v1, v2;
    logic [IW-1:0]         ptr_nxt;

    logic [IW-1:0]         ptr_q, ptr_d;
    logic [1:0]            tv_q, tv_d;
    logic [1:0][IW-1:0]    tid_q, tid_d;

    logic [NREQ-1:0]       route_rv;
    logic [NREQ*DW-1:0]    route_rd;
    logic                  pi;

    rr_pick2 #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win1    (win1),
        .win2    (win2),
        .id1     (id1),
        .id2     (id2),
        .v1      (v1),
        .v2      (v2),
        .ptr_nxt (ptr_nxt)
    );

    // Drive grants and ROM ports from the picker; all quiet during reset
    always_comb begin
        gnt       = '0;
        rom_en1   = 1'b0;
        rom_en2   = 1'b0;
        rom_addr1 = '0;
        rom_addr2 = '0;
        if (!rst) begin
            gnt     = win1 | win2;
            rom_en1 = v1;
            rom_en2 = v2;
            if (v1) begin
                rom_addr1 = addr[32'(id1)*AW +: AW];
            end
            if (v2) begin
                rom_addr2 = addr[32'(id2)*AW +: AW];
            end
        end
    end

    // Next pointer and per-port tags captured at the grant edge
    always_comb begin
        ptr_d      = ptr_nxt;
        tv_d       = '0;
        tid_d      = tid_q;
        tv_d[P1]   = v1;
        tv_d[P2]   = v2;
        tid_d[P1]  = id1;
        tid_d[P2]  = id2;
    end

    // Pointer and tag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            tv_q  <= '0;
            tid_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            tv_q  <= tv_d;
            tid_q <= tid_d;
        end
    end

    // Steer each port's ROM data onto its tagged requester lane
    always_comb begin
        route_rv = '0;
        route_rd = '0;
        pi       = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned p = 0; p < 2; p++) begin
                pi = 1'(p);
                if (tv_q[pi] && (tid_q[pi] == IW'(i))) begin
                    route_rv[i]          = 1'b1;
                    route_rd[i*DW +: DW] = (pi == P1) ? rom_dout1 : rom_dout2;
                end
            end
        end
    end

`ifdef ROM_ARB_OUTREG_EN
    logic [NREQ-1:0]    rvalid_q, rvalid_d;
    logic [NREQ*DW-1:0] rdata_q, rdata_d;

    // Output stage: new data on valid lanes, others hold
    always_comb begin
        rvalid_d = route_rv;
        rdata_d  = rdata_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (route_rv[i]) begin
                rdata_d[i*DW +: DW] = route_rd[i*DW +: DW];
            end
        end
    end

    // Registered rvalid/rdata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
`else
    assign rvalid = route_rv;
    assign rdata  = route_rd;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with NREQ=4 and a registered ROM model.
module tb_rom_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 16;
`ifdef ROM_ARB_OUTREG_EN
    localparam int LAT  = 2;
    localparam bit HOLD = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit HOLD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rvalid;
    logic [NREQ*DW-1:0] rdata;
    logic              rom_en1, rom_en2;
    logic [AW-1:0]     rom_addr1, rom_addr2;
    logic [DW-1:0]     rom_dout1 = '0;
    logic [DW-1:0]     rom_dout2 = '0;

    rom_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rom_en1   (rom_en1),
        .rom_en2   (rom_en2),
        .rom_addr1 (rom_addr1),
        .rom_addr2 (rom_addr2),
        .rom_dout1 (rom_dout1),
        .rom_dout2 (rom_dout2)
    );

    always #5 clk = ~clk;

    // Dual-address ROM model, mem[k] = 16'h1111*k, data one cycle after enable
    logic [DW-1:0] mem [8];
    initial for (int k = 0; k < 8; k++) mem[k] = 16'(16'h1111 * k);
    always @(posedge clk) begin
        if (rom_en1) rom_dout1 <= mem[rom_addr1];
        if (rom_en2) rom_dout2 <= mem[rom_addr2];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         lane;
        logic [15:0] data;
        int         due;
    } exp_t;

    exp_t        sb[$];
    int          mptr = 0;
    logic [15:0] held [NREQ];
    int          gcount [NREQ];
    int          errs = 0;
    int          checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] mk(input logic [2:0] a0, input logic [2:0] a1,
                                       input logic [2:0] a2, input logic [2:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Compare lane outputs with whatever the scoreboard has due this cycle
    task automatic check_out();
        logic [3:0]  erv;
        logic [63:0] erd;
        exp_t        e;
        erv = '0;
        erd = '0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due == cyc) begin
                erv[e.lane]  = 1'b1;
                held[e.lane] = e.data;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (erv[i] || HOLD) erd[i*16 +: 16] = held[i];
        end
        check_eq("rvalid", 64'(rvalid), 64'(erv));
        check_eq("rdata", rdata, erd);
    endtask

    // One clock of stimulus starting at a falling edge; checks grants now, lanes next edge
    task automatic cycle(input logic [3:0] r, input logic [11:0] a);
        logic [3:0] eg;
        logic       e1, e2;
        logic [2:0] a1, a2, la;
        int         n, idx, last;
        req  = r;
        addr = a;
        #1;
        eg = '0; e1 = 1'b0; e2 = 1'b0; a1 = '0; a2 = '0; n = 0; last = mptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (r[idx] && n < 2) begin
                eg[idx] = 1'b1;
                la = a[idx*3 +: 3];
                if (n == 0) begin e1 = 1'b1; a1 = la; end
                else        begin e2 = 1'b1; a2 = la; end
                sb.push_back('{lane: idx, data: 16'(16'h1111 * la), due: cyc + LAT});
                gcount[idx]++;
                last = idx;
                n++;
            end
        end
        if (n > 0) mptr = (last + 1) % NREQ;
        check_eq("gnt", 64'(gnt), 64'(eg));
        check_eq("rom_en1", 64'(rom_en1), 64'(e1));
        check_eq("rom_addr1", 64'(rom_addr1), 64'(a1));
        check_eq("rom_en2", 64'(rom_en2), 64'(e2));
        check_eq("rom_addr2", 64'(rom_addr2), 64'(a2));
        @(negedge clk);
        check_out();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin held[i] = '0; gcount[i] = 0; end

        // Reset state: no enables even with requests pending
        req = 4'b1111;
        @(negedge clk);
        #1;
        check_eq("rst_rvalid", 64'(rvalid), 64'd0);
        check_eq("rst_rdata", rdata, 64'd0);
        check_eq("rst_en1", 64'(rom_en1), 64'd0);
        check_eq("rst_en2", 64'(rom_en2), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req = '0;

        // Fairness from reset: all four held for four cycles
        for (int i = 0; i < 4; i++) cycle(4'b1111, mk(3'd1, 3'd2, 3'd3, 3'd4));
        for (int i = 0; i < NREQ; i++) check_eq($sformatf("fair_cnt%0d", i), 64'(gcount[i]), 64'd2);

        // Dual grant at ptr 0, then single requester 2 at addr 5
        cycle(4'b0011, mk(3'd2, 3'd7, 3'd0, 3'd0));
        cycle(4'b0100, mk(3'd0, 3'd0, 3'd5, 3'd0));
        for (int i = 0; i < 3; i++) cycle(4'b0000, '0);

        // Same address on two lanes
        cycle(4'b1010, mk(3'd0, 3'd4, 3'd0, 3'd4));
        cycle(4'b0000, '0);

        // Random mix
        for (int i = 0; i < 40; i++) cycle(4'($urandom), 12'($urandom));
        for (int i = 0; i < 3; i++) cycle(4'b0000, '0);

        // Reset two ns after a grant edge: the read must never surface
        req  = 4'b0100;
        addr = mk(3'd0, 3'd0, 3'd5, 3'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_rvalid", 64'(rvalid), 64'd0);
        check_eq("midrst_rdata", rdata, 64'd0);
        sb.delete();
        mptr = 0;
        for (int i = 0; i < NREQ; i++) held[i] = '0;
        @(negedge clk);
        check_eq("midrst_en1", 64'(rom_en1), 64'd0);
        check_eq("midrst_en2", 64'(rom_en2), 64'd0);
        @(negedge clk);
        check_eq("midrst_rvalid2", 64'(rvalid), 64'd0);
        rst = 1'b0;
        req = '0;
        cycle(4'b0000, '0);
        cycle(4'b1010, mk(3'd0, 3'd3, 3'd0, 3'd6));
        for (int i = 0; i < 3; i++) cycle(4'b0000, '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
